// File: rtl/spi_move_sequencer_pkg.sv
// Shared constants for the SPI move sequencer: register indices, CTRL and
// status bit positions, and the sequencing FSM state encoding.
package spi_move_sequencer_pkg;

    localparam logic [6:0] IDX_CTRL  = 7'h00;
    localparam logic [6:0] IDX_SPEED = 7'h01;
    localparam logic [6:0] IDX_MOVE  = 7'h02;

    localparam int CTRL_ENABLE  = 0;
    localparam int CTRL_ABORT   = 1;
    localparam int CTRL_FLUSH   = 2;
    localparam int CTRL_CLR_OVF = 3;

    localparam int STAT_ENABLE    = 0;
    localparam int STAT_BUSY      = 1;
    localparam int STAT_COUNT_LSB = 2;
    localparam int STAT_FULL      = 7;
    localparam int STAT_OVERFLOW  = 8;
    localparam int STAT_READY     = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ISSUE = 2'd2,
        RUN   = 2'd3
    } state_t;

endpackage

// File: rtl/spi_move_sequencer_fifo.sv
// Move-command FIFO: synchronous, first-word-fall-through, power-of-two depth.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module move_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_Rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (i_Rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/spi_move_sequencer.sv
// Decodes SPI write frames into config registers and a move queue, then
// sequences queued moves into the stepper core over valid/ready.
module spi_move_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int STEPS_W    = 24,
    parameter int PERIOD_W   = 16
) (
    input  logic                clk,
    input  logic                i_Rst,
    input  logic                spi_rx,
    input  logic [7:0]          spi_address_bits,
    input  logic [31:0]         spi_data_bits,
    output logic [31:0]         spi_reg_0,
    output logic [31:0]         spi_reg_1,
    output logic [31:0]         spi_reg_2,
    output logic [31:0]         spi_reg_3,
    output logic                motor_enable,
    output logic [PERIOD_W-1:0] step_period,
    output logic                move_valid,
    input  logic                move_ready,
    output logic [STEPS_W-1:0]  move_steps,
    output logic                move_dir,
    input  logic                move_done,
    output logic                move_abort
);
    import spi_move_sequencer_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH);

    state_t               state;
    state_t               state_next;
    logic                 spi_rx_q;
    logic                 wr;
    logic                 wr_ctrl;
    logic                 wr_speed;
    logic                 wr_move;
    logic                 abort;
    logic                 flush;
    logic                 clr_ovf;
    logic                 push;
    logic                 pop;
    logic                 busy;
    logic                 enable;
    logic                 overflow;
    logic [PERIOD_W-1:0]  period;
    logic [31:0]          done_cnt;
    logic [STEPS_W:0]     cur_move;
    logic [STEPS_W:0]     fifo_head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CW:0]          fifo_count;
    logic [31:0]          status_word;
    logic [31:0]          move_word;
    logic                 unused_data;

    // Only the rising edge of the frame-complete level counts as a write.
    assign wr       = spi_rx && !spi_rx_q && spi_address_bits[7];
    assign wr_ctrl  = wr && (spi_address_bits[6:0] == IDX_CTRL);
    assign wr_speed = wr && (spi_address_bits[6:0] == IDX_SPEED);
    assign wr_move  = wr && (spi_address_bits[6:0] == IDX_MOVE);
    assign abort    = wr_ctrl && spi_data_bits[CTRL_ABORT];
    assign flush    = wr_ctrl && spi_data_bits[CTRL_FLUSH];
    assign clr_ovf  = wr_ctrl && spi_data_bits[CTRL_CLR_OVF];
    assign push     = wr_move && (spi_data_bits[STEPS_W-1:0] != '0);
    assign pop      = (state == IDLE) && enable && !fifo_empty && !flush;

    assign motor_enable = enable;
    assign step_period  = period;
    assign unused_data  = ^spi_data_bits;

    move_fifo #(
        .WIDTH (STEPS_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .i_Rst   (i_Rst),
        .push    (push),
        .pop     (pop),
        .flush   (flush),
        .wr_data ({spi_data_bits[31], spi_data_bits[STEPS_W-1:0]}),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (i_Rst) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pop) state_next = LOAD;
            LOAD:    state_next = abort ? IDLE : ISSUE;
            ISSUE:   if (abort) state_next = IDLE;
                     else if (move_ready) state_next = RUN;
            RUN:     if (abort || move_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != IDLE);
        move_valid = (state == ISSUE);
        move_steps = busy ? cur_move[STEPS_W-1:0] : '0;
        move_dir   = busy ? cur_move[STEPS_W] : 1'b0;

        status_word                          = '0;
        status_word[STAT_ENABLE]             = enable;
        status_word[STAT_BUSY]               = busy;
        status_word[STAT_COUNT_LSB +: 5]     = 5'(fifo_count);
        status_word[STAT_FULL]               = fifo_full;
        status_word[STAT_OVERFLOW]           = overflow;
        status_word[STAT_READY]              = move_ready;

        move_word                = '0;
        move_word[31]            = move_dir;
        move_word[STEPS_W-1:0]   = move_steps;
    end

    // Overflow is sticky: only a push that cannot find a slot sets it.
    always_ff @(posedge clk) begin
        if (i_Rst) begin
            spi_rx_q   <= 1'b0;
            enable     <= 1'b0;
            overflow   <= 1'b0;
            period     <= PERIOD_W'(1);
            done_cnt   <= '0;
            cur_move   <= '0;
            move_abort <= 1'b0;
        end else begin
            spi_rx_q   <= spi_rx;
            move_abort <= abort;
            if (wr_ctrl) enable <= spi_data_bits[CTRL_ENABLE];
            if (clr_ovf) overflow <= 1'b0;
            else if (push && fifo_full && !pop) overflow <= 1'b1;
            if (wr_speed)
                period <= (spi_data_bits[PERIOD_W-1:0] == '0) ? PERIOD_W'(1)
                                                              : spi_data_bits[PERIOD_W-1:0];
            if (pop) cur_move <= fifo_head;
            if ((state == RUN) && move_done && !abort) done_cnt <= done_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_Rst) begin
            spi_reg_0 <= '0;
            spi_reg_1 <= 32'd1;
            spi_reg_2 <= '0;
            spi_reg_3 <= '0;
        end else begin
            spi_reg_0 <= status_word;
            spi_reg_1 <= 32'(period);
            spi_reg_2 <= done_cnt;
            spi_reg_3 <= move_word;
        end
    end

endmodule
